// File: rtl/reclaim_pkg.sv
// Shared widths, ROB entry payload and recovery-walk state for rob_reg_reclaim.
package reclaim_pkg;

    localparam int unsigned RECLAIM_DEPTH = 16;
    localparam int unsigned RECLAIM_PR_W  = 6;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic                    has_rd;
        logic [RECLAIM_PR_W-1:0] p_rd_new;
        logic [RECLAIM_PR_W-1:0] p_rd_old;
    } rob_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        WALK = 2'd2
    } walk_state_t;

endpackage

// File: rtl/rob_recover_walker.sv
// Flush recovery walker: steps youngest-to-oldest over squashed entries, returning
// their new PRs one per cycle, and pulls the ROB tail back as it goes.
module rob_recover_walker
    import reclaim_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PR_W  = RECLAIM_PR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush_go,
    input  logic [IDX_W-1:0]        i_flush_idx,
    input  logic [IDX_W:0]          i_tail_eff,
    input  logic                    i_peek_has_rd,
    input  logic [RECLAIM_PR_W-1:0] i_peek_p_rd_new,
    output logic [IDX_W-1:0]        o_peek_idx_c,
    output logic                    o_inv_en_c,
    output logic [IDX_W-1:0]        o_inv_idx_c,
    output logic                    o_tail_ld_c,
    output logic [IDX_W:0]          o_tail_val_c,
    output logic                    o_stall_recover,
    output logic                    o_recover,
    output logic [PR_W-1:0]         o_pr_new_flush,
    output logic                    o_busy
);

    localparam int unsigned PTR_W = IDX_W + 1;

    walk_state_t      r_state;
    logic [PTR_W-1:0] r_walk_ptr;
    logic [IDX_W-1:0] r_stop;
    logic [PTR_W-1:0] w_walk_prev;
    logic             w_last;

    assign w_walk_prev = r_walk_ptr - PTR_W'(1);
    assign w_last      = (w_walk_prev[IDX_W-1:0] == r_stop);

    // The recover strobe is loaded one cycle early so it lines up with the WALK cycle
    // that invalidates the entry it reports.
    assign o_peek_idx_c = (r_state == WALK) ? w_walk_prev[IDX_W-1:0] : r_walk_ptr[IDX_W-1:0];
    assign o_inv_en_c   = (r_state == WALK);
    assign o_inv_idx_c  = r_walk_ptr[IDX_W-1:0];
    assign o_tail_ld_c  = (r_state == WALK);
    assign o_tail_val_c = r_walk_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_walk_ptr      <= '0;
            r_stop          <= '0;
            o_stall_recover <= 1'b0;
            o_recover       <= 1'b0;
            o_pr_new_flush  <= '0;
            o_busy          <= 1'b0;
        end else begin
            o_stall_recover <= 1'b0;
            o_recover       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_flush_go) begin
                        r_state         <= PREP;
                        r_walk_ptr      <= i_tail_eff - PTR_W'(1);
                        r_stop          <= i_flush_idx;
                        o_stall_recover <= 1'b1;
                        o_busy          <= 1'b1;
                    end
                end
                PREP: begin
                    r_state   <= WALK;
                    o_recover <= i_peek_has_rd;
                    if (i_peek_has_rd) begin
                        o_pr_new_flush <= PR_W'(i_peek_p_rd_new);
                    end
                end
                WALK: begin
                    r_walk_ptr <= w_walk_prev;
                    if (w_last) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        o_recover <= i_peek_has_rd;
                        if (i_peek_has_rd) begin
                            o_pr_new_flush <= PR_W'(i_peek_p_rd_new);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rob_reg_reclaim.sv
// In-order physical-register reclaim tracker: releases old PRs at commit and returns
// squashed new PRs on flush. Optional RECLAIM_PERF_EN adds saturating perf counters.
module rob_reg_reclaim
    import reclaim_pkg::*;
#(
    parameter int unsigned DEPTH = RECLAIM_DEPTH,
    parameter int unsigned PR_W  = RECLAIM_PR_W,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic             alloc_has_rd,
    input  logic [PR_W-1:0]  alloc_p_rd_new,
    input  logic [PR_W-1:0]  alloc_p_rd_old,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             full,
    output logic             empty,
    input  logic             complete_en,
    input  logic [IDX_W-1:0] complete_idx,
    input  logic             flush_req,
    input  logic [IDX_W-1:0] flush_idx,
    output logic             retire_reg,
    output logic [PR_W-1:0]  p_rd_old,
    output logic             commit_valid,
    output logic             stall_recover,
    output logic             recover,
    output logic [PR_W-1:0]  PR_new_flush,
    output logic             busy
`ifdef RECLAIM_PERF_EN
    ,
    output logic [31:0]      perf_commit_cnt,
    output logic [31:0]      perf_squash_cnt
`endif
);

    localparam int unsigned PTR_W = IDX_W + 1;

    rob_entry_t       r_rob [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic [IDX_W-1:0] w_flush_dist;
    logic [PTR_W-1:0] w_tail_eff;
    logic [PTR_W-1:0] w_count_eff;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_alloc_go;
    logic             w_commit_go;
    logic             w_flush_go;
    logic [IDX_W-1:0] w_peek_idx;
    logic             w_inv_en;
    logic [IDX_W-1:0] w_inv_idx;
    logic             w_tail_ld;
    logic [PTR_W-1:0] w_tail_ld_val;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[IDX_W] != r_tail[IDX_W]) && (w_head_idx == w_tail_idx);

    assign full      = w_full;
    assign empty     = w_empty;
    assign alloc_idx = w_tail_idx;
    assign busy      = w_busy;

    assign w_alloc_go  = alloc_en && !w_full && !w_busy;
    assign w_commit_go = r_rob[w_head_idx].valid && r_rob[w_head_idx].done && !w_busy && !flush_req;

    // An alloc landing on the flush edge is younger than the branch, so it joins the walk.
    assign w_tail_eff   = r_tail + PTR_W'(w_alloc_go);
    assign w_count_eff  = w_tail_eff - r_head;
    assign w_flush_dist = flush_idx - w_head_idx;
    assign w_flush_go   = flush_req && !w_busy && (({1'b0, w_flush_dist} + PTR_W'(1)) < w_count_eff);

    // Entry storage: alloc write, completion, commit pop and walk invalidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rob <= '{default: '0};
        end else begin
            if (complete_en) begin
                r_rob[complete_idx].done <= 1'b1;
            end
            if (w_alloc_go) begin
                r_rob[w_tail_idx] <= '{valid:    1'b1,
                                       done:     1'b0,
                                       has_rd:   alloc_has_rd,
                                       p_rd_new: RECLAIM_PR_W'(alloc_p_rd_new),
                                       p_rd_old: RECLAIM_PR_W'(alloc_p_rd_old)};
            end
            if (w_commit_go) begin
                r_rob[w_head_idx].valid <= 1'b0;
            end
            if (w_inv_en) begin
                r_rob[w_inv_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_commit_go) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_tail_ld) begin
                r_tail <= w_tail_ld_val;
            end else if (w_alloc_go) begin
                r_tail <= r_tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_valid <= 1'b0;
            retire_reg   <= 1'b0;
            p_rd_old     <= '0;
        end else begin
            commit_valid <= w_commit_go;
            retire_reg   <= w_commit_go && r_rob[w_head_idx].has_rd;
            if (w_commit_go) begin
                p_rd_old <= PR_W'(r_rob[w_head_idx].p_rd_old);
            end
        end
    end

    rob_recover_walker #(
        .IDX_W (IDX_W),
        .PR_W  (PR_W)
    ) u_walker (
        .clk             (clk),
        .rst             (rst),
        .i_flush_go      (w_flush_go),
        .i_flush_idx     (flush_idx),
        .i_tail_eff      (w_tail_eff),
        .i_peek_has_rd   (r_rob[w_peek_idx].has_rd),
        .i_peek_p_rd_new (r_rob[w_peek_idx].p_rd_new),
        .o_peek_idx_c    (w_peek_idx),
        .o_inv_en_c      (w_inv_en),
        .o_inv_idx_c     (w_inv_idx),
        .o_tail_ld_c     (w_tail_ld),
        .o_tail_val_c    (w_tail_ld_val),
        .o_stall_recover (stall_recover),
        .o_recover       (recover),
        .o_pr_new_flush  (PR_new_flush),
        .o_busy          (w_busy)
    );

`ifdef RECLAIM_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_commit_cnt <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (w_commit_go && (perf_commit_cnt != '1)) begin
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
            end
            if (w_inv_en && (perf_squash_cnt != '1)) begin
                perf_squash_cnt <= perf_squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_reg_reclaim.sv
// Bench for rob_reg_reclaim: directed scenarios plus random traffic against a
// queue-based reference model of the reclaim tracker.
module tb_rob_reg_reclaim;

    localparam int DEPTH = 16;
    localparam int PR_W  = 6;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst;
    logic             alloc_en;
    logic             alloc_has_rd;
    logic [PR_W-1:0]  alloc_p_rd_new;
    logic [PR_W-1:0]  alloc_p_rd_old;
    logic [IDX_W-1:0] alloc_idx;
    logic             full;
    logic             empty;
    logic             complete_en;
    logic [IDX_W-1:0] complete_idx;
    logic             flush_req;
    logic [IDX_W-1:0] flush_idx;
    logic             retire_reg;
    logic [PR_W-1:0]  p_rd_old;
    logic             commit_valid;
    logic             stall_recover;
    logic             recover;
    logic [PR_W-1:0]  PR_new_flush;
    logic             busy;
`ifdef RECLAIM_PERF_EN
    logic [31:0]      perf_commit_cnt;
    logic [31:0]      perf_squash_cnt;
`endif

    rob_reg_reclaim dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_en       (alloc_en),
        .alloc_has_rd   (alloc_has_rd),
        .alloc_p_rd_new (alloc_p_rd_new),
        .alloc_p_rd_old (alloc_p_rd_old),
        .alloc_idx      (alloc_idx),
        .full           (full),
        .empty          (empty),
        .complete_en    (complete_en),
        .complete_idx   (complete_idx),
        .flush_req      (flush_req),
        .flush_idx      (flush_idx),
        .retire_reg     (retire_reg),
        .p_rd_old       (p_rd_old),
        .commit_valid   (commit_valid),
        .stall_recover  (stall_recover),
        .recover        (recover),
        .PR_new_flush   (PR_new_flush),
        .busy           (busy)
`ifdef RECLAIM_PERF_EN
        ,
        .perf_commit_cnt(perf_commit_cnt),
        .perf_squash_cnt(perf_squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit has_rd;
        bit done;
        int pnew;
        int pold;
    } ment_t;

    typedef struct {
        bit stall;
        bit busy;
        bit rec;
        int pr;
    } sched_t;

    ment_t  q[$];
    sched_t sched[$];
    sched_t cur;
    int     m_head;
    bit     e_cv;
    bit     e_rr;
    int     e_old;
    int     n_err;
    int     n_chk;
    int     ret_log[$];
    int     rec_log[$];
    int     busy_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        sched.delete();
        cur    = '{stall: 1'b0, busy: 1'b0, rec: 1'b0, pr: 0};
        m_head = 0;
        e_cv   = 1'b0;
        e_rr   = 1'b0;
        e_old  = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        alloc_en     = 1'b0;
        alloc_has_rd = 1'b0;
        alloc_p_rd_new = '0;
        alloc_p_rd_old = '0;
        complete_en  = 1'b0;
        complete_idx = '0;
        flush_req    = 1'b0;
        flush_idx    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();
        rst = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, then compare one step after the edge.
    task automatic step(input bit a_en, input bit a_rd, input int a_new, input int a_old,
                        input bit c_en, input int c_idx, input bit f_req, input int f_idx);
        bit    cgo;
        bit    ago;
        bit    fgo;
        int    k;
        ment_t e;
        alloc_en       = a_en;
        alloc_has_rd   = a_rd;
        alloc_p_rd_new = PR_W'(a_new);
        alloc_p_rd_old = PR_W'(a_old);
        complete_en    = c_en;
        complete_idx   = IDX_W'(c_idx);
        flush_req      = f_req;
        flush_idx      = IDX_W'(f_idx);

        cgo  = !cur.busy && !f_req && (q.size() > 0) && q[0].done;
        ago  = a_en && (q.size() < DEPTH) && !cur.busy;
        e_cv = cgo;
        e_rr = cgo && q[0].has_rd;
        if (cgo) begin
            e_old = q[0].pold;
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (c_en) begin
            k = (c_idx - m_head + DEPTH) % DEPTH;
            if (k < q.size()) q[k].done = 1'b1;
        end
        if (ago) q.push_back('{has_rd: a_rd, done: 1'b0, pnew: a_new % 64, pold: a_old % 64});
        k   = (f_idx - m_head + DEPTH) % DEPTH;
        fgo = f_req && !cur.busy && (k + 1 < q.size());
        if (fgo) begin
            sched.push_back('{stall: 1'b1, busy: 1'b1, rec: 1'b0, pr: 0});
            while (q.size() > k + 1) begin
                e = q.pop_back();
                sched.push_back('{stall: 1'b0, busy: 1'b1, rec: e.has_rd, pr: e.pnew});
            end
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else cur = '{stall: 1'b0, busy: 1'b0, rec: 1'b0, pr: 0};

        @(posedge clk);
        #1;
        check("commit_valid", 32'(commit_valid), 32'(e_cv));
        check("retire_reg", 32'(retire_reg), 32'(e_rr));
        if (e_cv) check("p_rd_old", 32'(p_rd_old), 32'(e_old));
        check("stall_recover", 32'(stall_recover), 32'(cur.stall));
        check("busy", 32'(busy), 32'(cur.busy));
        check("recover", 32'(recover), 32'(cur.rec));
        if (cur.rec) check("PR_new_flush", 32'(PR_new_flush), 32'(cur.pr));
        if (!cur.busy) begin
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("alloc_idx", 32'(alloc_idx), 32'((m_head + q.size()) % DEPTH));
        end
        if (retire_reg) ret_log.push_back(int'(p_rd_old));
        if (busy) begin
            busy_cycles++;
            rec_log.push_back(recover ? int'(PR_new_flush) : -1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int occ;

    initial begin
        n_err = 0;
        n_chk = 0;
        model_clear();
        do_reset();

        // Reset state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        check("rst_strobes", {27'd0, retire_reg, commit_valid, stall_recover, recover, busy}, 32'd0);
        check("rst_p_rd_old", 32'(p_rd_old), 32'd0);
        check("rst_PR_new_flush", 32'(PR_new_flush), 32'd0);
        idle(2);

        // Three commits in consecutive cycles
        for (int i = 0; i < 3; i++) step(1, 1, i + 1, 31 - i, 0, 0, 0, 0);
        ret_log.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, i, 0, 0);
        idle(2);
        check("retire_count", 32'(ret_log.size()), 32'd3);
        if (ret_log.size() == 3) begin
            check("retire_0", 32'(ret_log[0]), 32'd31);
            check("retire_1", 32'(ret_log[1]), 32'd30);
            check("retire_2", 32'(ret_log[2]), 32'd29);
        end

        // Fill, overflow, commit then refill across the wrap
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, i, i, 0, 0, 0, 0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_wrap_idx", 32'(alloc_idx), 32'd0);
        step(1, 1, 40, 40, 0, 0, 0, 0);
        check("overflow_full", 32'(full), 32'd1);
        step(1, 1, 41, 41, 1, 0, 0, 0);
        step(1, 1, 42, 42, 0, 0, 0, 0);
        check("after_commit_full", 32'(full), 32'd0);
        step(1, 1, 43, 43, 0, 0, 0, 0);
        check("refill_full", 32'(full), 32'd1);
        check("refill_idx", 32'(alloc_idx), 32'd1);

        // Flush walk with a no-rd gap
        do_reset();
        for (int i = 0; i < 5; i++) step(1, (i != 1), 32 + i, i, 0, 0, 0, 0);
        rec_log.delete();
        busy_cycles = 0;
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("walk_stall", 32'(stall_recover), 32'd1);
        idle(6);
        check("walk_busy_cycles", 32'(busy_cycles), 32'd5);
        check("walk_rec_count", 32'(rec_log.size()), 32'd5);
        if (rec_log.size() == 5) begin
            check("walk_rec_1", 32'(rec_log[1]), 32'h24);
            check("walk_rec_2", 32'(rec_log[2]), 32'h23);
            check("walk_rec_3", 32'(rec_log[3]), 32'h22);
            check("walk_rec_gap", 32'(rec_log[4]), 32'hffff_ffff);
        end
        check("walk_alloc_idx", 32'(alloc_idx), 32'd1);

        // Flush beats a done head; commit follows the walk
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 8 + i, 10 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        ret_log.delete();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("flush_blocks_commit", 32'(retire_reg), 32'd0);
        idle(6);
        check("post_walk_commits", 32'(ret_log.size()), 32'd1);
        if (ret_log.size() == 1) check("post_walk_old", 32'(ret_log[0]), 32'd10);

        // Reset during WALK
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 32 + i, i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_recover", 32'(recover), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        model_clear();
        rst = 1'b1;
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int c_idx;
            int f_idx;
            occ   = q.size();
            c_idx = (occ > 0 && ($urandom % 4) != 0) ?
                    (m_head + int'($urandom_range(occ - 1, 0))) % DEPTH : int'($urandom % DEPTH);
            f_idx = (occ > 0 && ($urandom % 4) != 0) ?
                    (m_head + int'($urandom_range(occ - 1, 0))) % DEPTH : int'($urandom % DEPTH);
            step(($urandom % 100) < 55, ($urandom % 4) != 0, int'($urandom % 64), int'($urandom % 64),
                 ($urandom % 100) < 50, c_idx, ($urandom % 100) < 5, f_idx);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
